// File: rtl/scroll_pkg.sv
// Shared encodings and screen geometry for the digit scroll sequencer.
package scroll_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SCROLL = 2'd2
   } scroll_state_e;

   localparam logic [3:0] GLYPH_BLANK = 4'd13;
   localparam int         GLYPH_W     = 43;
   localparam int         H_ACTIVE    = 640;
   localparam int         V_ACTIVE    = 480;

endpackage

// File: rtl/digit_fifo.sv
// Glyph code queue: pointer-plus-count FIFO with the head visible combinationally.
module digit_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [3:0] din,
   output logic [3:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [3:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok;
   logic          pop_ok;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign dout  = mem_q[rd_ptr_q];

   // full is sampled before any same-cycle pop, so a push while full is dropped
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/digit_scroll_ctrl.sv
// Queues glyph codes and scrolls each one right-to-left, one STEP per frame.
//
// state  | meaning
// IDLE   | nothing shown, waiting for a queued glyph
// LOAD   | pop head of queue into result, border to entry position
// SCROLL | move border left each unpaused frame tick until the glyph exits
module digit_scroll_ctrl
   import scroll_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int STEP         = 2,
   parameter int BORDER_START = H_ACTIVE + GLYPH_W,
   parameter int BORDER_END   = GLYPH_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] h_cnt,
   input  logic [9:0] v_cnt,
   input  logic       push,
   input  logic [3:0] push_code,
   input  logic       pause,
   output logic       full,
   output logic       busy,
   output logic [3:0] result,
   output logic [9:0] border
);

   localparam logic [9:0] START_W = 10'(BORDER_START);
   localparam logic [9:0] STEP_W  = 10'(STEP);
   // border - STEP <= BORDER_END, rearranged so the subtract can never wrap
   localparam logic [9:0] EXIT_AT = 10'(BORDER_END + STEP);

   scroll_state_e state_q, state_d;
   logic [3:0]    result_q, result_d;
   logic [9:0]    border_q, border_d;
   logic          pop;
   logic          tick;
   logic          fifo_empty;
   logic [3:0]    fifo_dout;

   digit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_code),
      .dout  (fifo_dout),
      .full  (full),
      .empty (fifo_empty)
   );

   assign tick   = (h_cnt == '0) && (v_cnt == 10'(V_ACTIVE));
   assign busy   = (state_q != ST_IDLE) || !fifo_empty;
   assign result = result_q;
   assign border = border_q;

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      border_d = border_q;
      pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            result_d = GLYPH_BLANK;
            border_d = START_W;
            if (!fifo_empty) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            pop      = 1'b1;
            result_d = fifo_dout;
            border_d = START_W;
            state_d  = ST_SCROLL;
         end
         ST_SCROLL: begin
            if (tick && !pause) begin
               if (border_q <= EXIT_AT) begin
                  result_d = GLYPH_BLANK;
                  border_d = START_W;
                  state_d  = fifo_empty ? ST_IDLE : ST_LOAD;
               end else begin
                  border_d = border_q - STEP_W;
               end
            end
         end
         default: begin
            result_d = GLYPH_BLANK;
            border_d = START_W;
            state_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= GLYPH_BLANK;
         border_q <= START_W;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         border_q <= border_d;
      end
   end

endmodule

// File: tb/tb_digit_scroll_ctrl.sv
// Directed bench for digit_scroll_ctrl with hand-computed expectations.
module tb_digit_scroll_ctrl;

   logic       clk;
   logic       rst;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       push;
   logic [3:0] push_code;
   logic       pause;
   logic       full;
   logic       busy;
   logic [3:0] result;
   logic [9:0] border;

   int n_checks = 0;
   int n_fail   = 0;

   digit_scroll_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .push      (push),
      .push_code (push_code),
      .pause     (pause),
      .full      (full),
      .busy      (busy),
      .result    (result),
      .border    (border)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish, time %0t required below 1000000", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // one clock with the frame tick decode true
   task automatic tick();
      h_cnt = 10'd0;
      v_cnt = 10'd480;
      cyc(1);
      h_cnt = 10'd1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic do_push(input logic [3:0] code);
      push      = 1'b1;
      push_code = code;
      cyc(1);
      push      = 1'b0;
   endtask

   // glyph has just been loaded; scroll it out and stop on the exit tick
   task automatic run_glyph(input logic [3:0] code);
      check_eq("glyph_code", 32'(result), 32'(code));
      check_eq("glyph_entry_border", 32'(border), 32'd683);
      ticks(319);
      check_eq("glyph_last_border", 32'(border), 32'd45);
      check_eq("glyph_still_shown", 32'(result), 32'(code));
      tick();
      check_eq("exit_result_blank", 32'(result), 32'd13);
      check_eq("exit_border_reset", 32'(border), 32'd683);
   endtask

   initial begin
      rst       = 1'b1;
      h_cnt     = 10'd1;
      v_cnt     = 10'd0;
      push      = 1'b0;
      push_code = 4'd0;
      pause     = 1'b0;
      #1;
      check_eq("rst_result", 32'(result), 32'd13);
      check_eq("rst_border", 32'(border), 32'd683);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_full", 32'(full), 32'd0);
      cyc(2);
      rst = 1'b0;
      cyc(2);

      // single glyph: latency, full scroll, exit into IDLE
      do_push(4'd7);
      check_eq("busy_after_push", 32'(busy), 32'd1);
      check_eq("blank_e0", 32'(result), 32'd13);
      cyc(1);
      check_eq("blank_e1", 32'(result), 32'd13);
      cyc(1);
      check_eq("first_shown", 32'(result), 32'd7);
      tick();
      check_eq("first_tick_border", 32'(border), 32'd681);
      ticks(318);
      check_eq("tick319_border", 32'(border), 32'd45);
      tick();
      check_eq("tick320_result", 32'(result), 32'd13);
      check_eq("tick320_border", 32'(border), 32'd683);
      check_eq("tick320_busy", 32'(busy), 32'd0);
      cyc(3);
      check_eq("idle_stays_blank", 32'(result), 32'd13);

      // fill the queue behind a scrolling glyph, pause mid-scroll
      do_push(4'd9);
      cyc(2);
      check_eq("nine_shown", 32'(result), 32'd9);
      do_push(4'd1);
      do_push(4'd2);
      do_push(4'd3);
      check_eq("not_full_at_3", 32'(full), 32'd0);
      do_push(4'd4);
      check_eq("full_at_4", 32'(full), 32'd1);
      do_push(4'd5);
      check_eq("full_after_drop", 32'(full), 32'd1);
      ticks(91);
      check_eq("border_501", 32'(border), 32'd501);
      pause = 1'b1;
      ticks(10);
      check_eq("paused_border", 32'(border), 32'd501);
      pause = 1'b0;
      tick();
      check_eq("unpaused_border", 32'(border), 32'd499);
      ticks(227);
      check_eq("nine_last_border", 32'(border), 32'd45);
      tick();
      check_eq("nine_exit_result", 32'(result), 32'd13);
      check_eq("nine_exit_border", 32'(border), 32'd683);
      cyc(1);
      run_glyph(4'd1);
      cyc(1);
      run_glyph(4'd2);
      cyc(1);
      run_glyph(4'd3);
      cyc(1);
      run_glyph(4'd4);
      check_eq("seq_end_busy", 32'(busy), 32'd0);
      cyc(2);
      check_eq("seq_end_blank", 32'(result), 32'd13);

      // reset mid-scroll with two glyphs waiting
      do_push(4'd5);
      cyc(2);
      do_push(4'd6);
      do_push(4'd8);
      ticks(191);
      check_eq("border_301", 32'(border), 32'd301);
      rst = 1'b1;
      #1;
      check_eq("midrst_result", 32'(result), 32'd13);
      check_eq("midrst_border", 32'(border), 32'd683);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      cyc(1);
      rst = 1'b0;
      cyc(5);
      check_eq("postrst_result", 32'(result), 32'd13);
      check_eq("postrst_busy", 32'(busy), 32'd0);

      // push while full coinciding with the LOAD pop is dropped
      do_push(4'd2);
      cyc(2);
      do_push(4'd10);
      do_push(4'd11);
      do_push(4'd12);
      do_push(4'd15);
      check_eq("full_before_exit", 32'(full), 32'd1);
      run_glyph(4'd2);
      check_eq("full_in_load", 32'(full), 32'd1);
      do_push(4'd0);
      check_eq("load_pop_result", 32'(result), 32'd10);
      check_eq("load_pop_full", 32'(full), 32'd0);
      run_glyph(4'd10);
      cyc(1);
      run_glyph(4'd11);
      cyc(1);
      run_glyph(4'd12);
      cyc(1);
      run_glyph(4'd15);
      cyc(1);
      check_eq("dropped_never_shown", 32'(result), 32'd13);
      check_eq("final_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/digit_scroll_ctrl.md
# digit_scroll_ctrl

Sequencer for the VGA digit glyph renderer. Queues 4-bit glyph codes from the keypad/calculator logic and presents them to the renderer one at a time as `result`. Each glyph scrolls right-to-left across the active area by driving the renderer's horizontal anchor `border` once per frame. Sits between the input/arithmetic logic and the pixel generator, sharing the `h_cnt`/`v_cnt` bus from the VGA timing controller.

## Interface
Parameters:
- FIFO_DEPTH, 4: glyph queue depth, power of two.
- STEP, 2: pixels `border` moves per frame.
- BORDER_START, 683: `border` at glyph entry (640 + 43; glyph fully off-right).
- BORDER_END, 43: exit threshold (glyph fully off-left).

Ports:
- clk  in  1  pixel clock (25 MHz), sole clock.
- rst  in  1  asynchronous, active-high reset.
- h_cnt  in  10  horizontal pixel counter.
- v_cnt  in  10  vertical line counter.
- push  in  1  enqueue request.
- push_code  in  4  glyph code (0-9 digits, 10 '+', 11 '-', 12 'x', 15 '='; 13/14 render blank).
- pause  in  1  freeze scrolling while high.
- full  out  1  queue holds FIFO_DEPTH entries.
- busy  out  1  state is not IDLE, or the queue is non-empty.
- result  out  4  glyph code to renderer; 4'd13 (BLANK) when nothing is shown.
- border  out  10  glyph anchor to renderer.

## Operation
- Frame tick: internal one-cycle pulse when `h_cnt==0 && v_cnt==480` (start of vertical blank). Only this pulse advances `border`.
- Queue: synchronous FIFO.
  - A push is accepted when `push && !full`, using `full` from before any same-cycle pop.
  - Push and pop in the same cycle with the queue not full: count unchanged, both take effect.
  - A push while full is dropped; no other effect.
- FSM states:
  - IDLE: `result`=BLANK, `border`=BORDER_START. Go to LOAD when the queue is non-empty.
  - LOAD: pop the head; register `result`←head, `border`←BORDER_START; go to SCROLL. A tick arriving in LOAD is ignored.
  - SCROLL: on a tick with `pause` low:
    - If `border - STEP <= BORDER_END`: `result`←BLANK, `border`←BORDER_START; go to LOAD if the queue is non-empty, else IDLE.
    - Otherwise: `border`←`border - STEP`.
    - Ticks with `pause` high are ignored, and `border` holds.
- Arithmetic: the 10-bit unsigned compare is evaluated before the subtract, so `border` never wraps below BORDER_END.
- With default parameters each glyph is shown for exactly 319 frames. It is blanked on the 320th tick.

## Timing
- Reset values (asynchronous, immediate): state IDLE, FIFO empty, `full`=0, `busy`=0, `result`=4'd13, `border`=BORDER_START.
- Latency, push into an empty, idle block:
  - Push sampled at edge E0; FIFO count becomes 1.
  - E1: IDLE→LOAD.
  - E2: `result` and `border` valid; state SCROLL.
  - `busy` goes high after E0.
- Back-to-back glyphs: the exit tick edge loads BLANK and enters LOAD. The next glyph appears one cycle later, well inside vertical blank, so no partial-frame glyph is ever drawn.
- `full` and `busy` are registered-state functions with no combinational path from `push`.
- Reset mid-scroll: the queue is discarded and the block returns to the reset values. The next frame renders blank.

## Structure
- Shared package `scroll_pkg`: state encodings (IDLE=0, LOAD=1, SCROLL=2), `GLYPH_BLANK`=4'd13, `GLYPH_W`=43, `H_ACTIVE`=640, `V_ACTIVE`=480.
- One sub-module, `digit_fifo`:
  - Parameterised depth, 4-bit data.
  - Ports push/pop/din/dout/full/empty.
  - Pointer plus count implementation, with `dout` showing the head combinationally.
- The top module holds the tick decode, the FSM and the `border` register.

## Test plan
- Reset, then push code 7 → after 2 cycles `result`=7, `border`=683. After 1 tick `border`=681. After 319 ticks `border`=45. On tick 320: `result`=13, `border`=683, `busy`=0.
- Push 1, 2, 3, 4, 5 back-to-back with no pops → `full`=1 after the 4th push, the 5th is dropped. The glyph sequence shown is 1, 2, 3, 4, then IDLE.
- Hold `pause` for 10 ticks mid-scroll at `border`=501 → `border` stays 501. Release → the next tick gives 499.
- Queue holds a glyph when the current one exits → on the exit tick `result`=13. One cycle later `result`=next code and `border`=683, with `v_cnt` still ≥480.
- Assert `rst` at `border`=301 with 2 glyphs queued → `result`=13 and `border`=683 immediately. After release no glyph appears without a new push.
- Push while full with a simultaneous pop (LOAD cycle) → the push is dropped and count drops by 1.
